// File: rtl/execute_stage_pkg.sv
// Shared Y86-64 execute-stage constants, E-register layout and condition evaluation.
// Used by execute_stage, its ALU and the decode/execute interface.
package execute_stage_pkg;

   localparam int unsigned NibbleW = 4;
   localparam int unsigned WordW   = 64;

   typedef logic [NibbleW-1:0] nibble_t;
   typedef logic [WordW-1:0]   word_t;

   localparam nibble_t IcHalt   = 4'h0;
   localparam nibble_t IcNop    = 4'h1;
   localparam nibble_t IcCmovq  = 4'h2;
   localparam nibble_t IcIrmovq = 4'h3;
   localparam nibble_t IcRmmovq = 4'h4;
   localparam nibble_t IcMrmovq = 4'h5;
   localparam nibble_t IcOpq    = 4'h6;
   localparam nibble_t IcJxx    = 4'h7;
   localparam nibble_t IcCall   = 4'h8;
   localparam nibble_t IcRet    = 4'h9;
   localparam nibble_t IcPushq  = 4'hA;
   localparam nibble_t IcPopq   = 4'hB;

   localparam nibble_t RRsp  = 4'h4;
   localparam nibble_t RNone = 4'hF;

   localparam nibble_t FnAdd = 4'h0;
   localparam nibble_t FnSub = 4'h1;
   localparam nibble_t FnAnd = 4'h2;
   localparam nibble_t FnXor = 4'h3;

   localparam nibble_t CndAlways = 4'h0;
   localparam nibble_t CndLe     = 4'h1;
   localparam nibble_t CndL      = 4'h2;
   localparam nibble_t CndE      = 4'h3;
   localparam nibble_t CndNe     = 4'h4;
   localparam nibble_t CndGe     = 4'h5;
   localparam nibble_t CndG      = 4'h6;

   typedef enum logic [1:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluXor
   } alu_op_e;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CcReset = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   typedef struct packed {
      nibble_t icode;
      nibble_t ifun;
      word_t   valc;
      word_t   vala;
      word_t   valb;
      nibble_t dste;
      nibble_t dstm;
      nibble_t srca;
      nibble_t srcb;
   } e_reg_t;

   localparam e_reg_t EBubble = '{
      icode: IcNop, ifun: 4'h0, valc: '0, vala: '0, valb: '0,
      dste: RNone, dstm: RNone, srca: RNone, srcb: RNone
   };

   // Unknown function codes fall back to add.
   function automatic alu_op_e alu_decode(input nibble_t fun);
      alu_op_e op;
      case (fun)
         FnSub:   op = AluSub;
         FnAnd:   op = AluAnd;
         FnXor:   op = AluXor;
         default: op = AluAdd;
      endcase
      return op;
   endfunction

   function automatic logic cond_eval(input cc_t cc, input nibble_t fun);
      logic lt;
      logic res;
      lt = cc.sf ^ cc.of;
      case (fun)
         CndAlways: res = 1'b1;
         CndLe:     res = lt | cc.zf;
         CndL:      res = lt;
         CndE:      res = cc.zf;
         CndNe:     res = ~cc.zf;
         CndGe:     res = ~lt;
         CndG:      res = ~lt & ~cc.zf;
         default:   res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode/execute bundle: decode outputs and stall/exception controls in, E-stage results out.
// master drives decode-side signals, slave is the execute stage.
interface execute_stage_if;
   import execute_stage_pkg::*;

   logic    E_bubble_i;
   nibble_t d_icode_i;
   nibble_t d_ifun_i;
   word_t   d_valC_i;
   word_t   d_valA_i;
   word_t   d_valB_i;
   nibble_t d_dstE_i;
   nibble_t d_dstM_i;
   nibble_t d_srcA_i;
   nibble_t d_srcB_i;
   logic    m_exc_i;
   logic    W_exc_i;

   nibble_t E_icode_o;
   nibble_t E_ifun_o;
   nibble_t E_srcA_o;
   nibble_t E_srcB_o;
   nibble_t E_dstM_o;
   word_t   E_valA_o;
   word_t   e_valE_o;
   nibble_t e_dstE_o;
   logic    e_Cnd_o;
   logic [2:0] cc_o;

   modport master (
      output E_bubble_i, d_icode_i, d_ifun_i, d_valC_i, d_valA_i, d_valB_i,
             d_dstE_i, d_dstM_i, d_srcA_i, d_srcB_i, m_exc_i, W_exc_i,
      input  E_icode_o, E_ifun_o, E_srcA_o, E_srcB_o, E_dstM_o, E_valA_o,
             e_valE_o, e_dstE_o, e_Cnd_o, cc_o
   );

   modport slave (
      input  E_bubble_i, d_icode_i, d_ifun_i, d_valC_i, d_valA_i, d_valB_i,
             d_dstE_i, d_dstM_i, d_srcA_i, d_srcB_i, m_exc_i, W_exc_i,
      output E_icode_o, E_ifun_o, E_srcA_o, E_srcB_o, E_dstM_o, E_valA_o,
             e_valE_o, e_dstE_o, e_Cnd_o, cc_o
   );

endinterface

// File: rtl/execute_stage_alu64.sv
// 64-bit Y86 ALU: computes B op A with wrap-around arithmetic and derives ZF/SF/OF.
// Purely combinational.
module execute_stage_alu64
   import execute_stage_pkg::*;
(
   input  word_t   i_a,
   input  word_t   i_b,
   input  nibble_t i_fun,
   output word_t   o_result,
   output logic    o_zf,
   output logic    o_sf,
   output logic    o_of
);

   word_t w_res;
   logic  w_of;

   always_comb begin
      w_res = i_b + i_a;
      w_of  = (i_a[63] == i_b[63]) && (w_res[63] != i_a[63]);
      unique case (alu_decode(i_fun))
         AluAdd: begin
            w_res = i_b + i_a;
            w_of  = (i_a[63] == i_b[63]) && (w_res[63] != i_a[63]);
         end
         AluSub: begin
            w_res = i_b - i_a;
            w_of  = (i_a[63] != i_b[63]) && (w_res[63] != i_b[63]);
         end
         AluAnd: begin
            w_res = i_b & i_a;
            w_of  = 1'b0;
         end
         AluXor: begin
            w_res = i_b ^ i_a;
            w_of  = 1'b0;
         end
      endcase
   end

   assign o_result = w_res;
   assign o_zf     = (w_res == '0);
   assign o_sf     = w_res[63];
   assign o_of     = w_of;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU operand selection, CC register and Cnd.
// Define EXEC_EXC_GUARD_EN to block CC writes while memory or writeback holds an exception.
module execute_stage
   import execute_stage_pkg::*;
(
   input logic           clk_i,
   input logic           rstn_i,
   execute_stage_if.slave ex_if
);

   e_reg_t  r_e;
   cc_t     r_cc;
   e_reg_t  w_e_in;
   word_t   w_alu_a;
   word_t   w_alu_b;
   nibble_t w_alu_fun;
   word_t   w_alu_res;
   cc_t     w_alu_cc;
   logic    w_cnd;
   logic    w_cc_we;

   always_comb begin
      w_e_in       = EBubble;
      w_e_in.icode = ex_if.d_icode_i;
      w_e_in.ifun  = ex_if.d_ifun_i;
      w_e_in.valc  = ex_if.d_valC_i;
      w_e_in.vala  = ex_if.d_valA_i;
      w_e_in.valb  = ex_if.d_valB_i;
      w_e_in.dste  = ex_if.d_dstE_i;
      w_e_in.dstm  = ex_if.d_dstM_i;
      w_e_in.srca  = ex_if.d_srcA_i;
      w_e_in.srcb  = ex_if.d_srcB_i;
   end

   always_comb begin
      w_alu_a = '0;
      case (r_e.icode)
         IcCmovq, IcOpq:               w_alu_a = r_e.vala;
         IcIrmovq, IcRmmovq, IcMrmovq: w_alu_a = r_e.valc;
         IcCall, IcPushq:              w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
         IcRet, IcPopq:                w_alu_a = 64'd8;
         default:                      w_alu_a = '0;
      endcase
   end

   always_comb begin
      w_alu_b = '0;
      case (r_e.icode)
         IcRmmovq, IcMrmovq, IcOpq, IcCall, IcPushq, IcRet, IcPopq: w_alu_b = r_e.valb;
         default:                                                   w_alu_b = '0;
      endcase
   end

   assign w_alu_fun = (r_e.icode == IcOpq) ? r_e.ifun : FnAdd;

   execute_stage_alu64 u_alu (
      .i_a      (w_alu_a),
      .i_b      (w_alu_b),
      .i_fun    (w_alu_fun),
      .o_result (w_alu_res),
      .o_zf     (w_alu_cc.zf),
      .o_sf     (w_alu_cc.sf),
      .o_of     (w_alu_cc.of)
   );

   // Cnd uses the flags as they stand before this instruction's own CC write.
   assign w_cnd = cond_eval(r_cc, r_e.ifun);

`ifdef EXEC_EXC_GUARD_EN
   assign w_cc_we = (r_e.icode == IcOpq) && !ex_if.m_exc_i && !ex_if.W_exc_i;
`else
   logic w_unused_exc;
   assign w_unused_exc = ex_if.m_exc_i ^ ex_if.W_exc_i;
   assign w_cc_we      = (r_e.icode == IcOpq);
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_e  <= EBubble;
         r_cc <= CcReset;
      end else begin
         r_e <= ex_if.E_bubble_i ? EBubble : w_e_in;
         if (w_cc_we) begin
            r_cc <= w_alu_cc;
         end
      end
   end

   assign ex_if.E_icode_o = r_e.icode;
   assign ex_if.E_ifun_o  = r_e.ifun;
   assign ex_if.E_srcA_o  = r_e.srca;
   assign ex_if.E_srcB_o  = r_e.srcb;
   assign ex_if.E_dstM_o  = r_e.dstm;
   assign ex_if.E_valA_o  = r_e.vala;
   assign ex_if.e_valE_o  = w_alu_res;
   assign ex_if.e_dstE_o  = ((r_e.icode == IcCmovq) && !w_cnd) ? RNone : r_e.dste;
   assign ex_if.e_Cnd_o   = w_cnd;
   assign ex_if.cc_o      = r_cc;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed test-plan cases followed by random traffic,
// checked against a behavioural model of the Y86 execute rules.
module tb_execute_stage;
   import execute_stage_pkg::*;

`ifdef EXEC_EXC_GUARD_EN
   localparam bit Guard = 1'b1;
`else
   localparam bit Guard = 1'b0;
`endif

   typedef struct {
      logic [3:0]  icode, ifun, dste, dstm, srca, srcb;
      logic [63:0] valc, vala, valb;
   } ins_t;

   typedef struct {
      int          due;
      logic [3:0]  icode, ifun, srca, srcb, dstm, dste;
      logic [63:0] vala, vale;
      logic        cnd;
      logic [2:0]  cc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   logic [2:0] mcc = 3'b100;
   bit   pend_m = 1'b0;
   bit   pend_w = 1'b0;

   execute_stage_if ex_if ();

   execute_stage u_dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .ex_if  (ex_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic ins_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                               input logic [63:0] valc, input logic [63:0] vala,
                               input logic [63:0] valb, input logic [3:0] dste);
      ins_t i;
      i.icode = icode; i.ifun = ifun; i.valc = valc; i.vala = vala; i.valb = valb;
      i.dste = dste; i.dstm = RNone; i.srca = 4'h3; i.srcb = RRsp;
      return i;
   endfunction

   // Drive one decode slot; the expected E-cycle view is pushed to the scoreboard.
   task automatic issue(input ins_t ins, input bit bub, input bit em, input bit ew, input bit rst);
      exp_t e;
      ins_t f;
      logic [63:0] a, b, r;
      logic signed [64:0] s;
      logic zf, sf, of, lt;
      @(posedge clk);
      #1;
      rstn = ~rst;
      ex_if.E_bubble_i = bub;
      ex_if.d_icode_i = ins.icode; ex_if.d_ifun_i = ins.ifun;
      ex_if.d_valC_i = ins.valc; ex_if.d_valA_i = ins.vala; ex_if.d_valB_i = ins.valb;
      ex_if.d_dstE_i = ins.dste; ex_if.d_dstM_i = ins.dstm;
      ex_if.d_srcA_i = ins.srca; ex_if.d_srcB_i = ins.srcb;
      ex_if.m_exc_i = pend_m; ex_if.W_exc_i = pend_w;
      pend_m = em; pend_w = ew;
      if (rst || bub) f = mk(IcNop, 4'h0, 64'h0, 64'h0, 64'h0, RNone);
      else f = ins;
      if (rst || bub) begin
         f.srca = RNone; f.srcb = RNone;
      end
      if (rst) mcc = 3'b100;
      case (f.icode)
         IcCmovq, IcOpq:               a = f.vala;
         IcIrmovq, IcRmmovq, IcMrmovq: a = f.valc;
         IcCall, IcPushq:              a = 64'hFFFF_FFFF_FFFF_FFF8;
         IcRet, IcPopq:                a = 64'd8;
         default:                      a = 64'd0;
      endcase
      case (f.icode)
         IcRmmovq, IcMrmovq, IcOpq, IcCall, IcPushq, IcRet, IcPopq: b = f.valb;
         default: b = 64'd0;
      endcase
      of = 1'b0;
      if (f.icode == IcOpq && f.ifun == 4'h1) begin
         r = b - a;
         s = $signed({b[63], b}) - $signed({a[63], a});
         of = (s != $signed({r[63], r}));
      end else if (f.icode == IcOpq && f.ifun == 4'h2) begin
         r = a & b;
      end else if (f.icode == IcOpq && f.ifun == 4'h3) begin
         r = a ^ b;
      end else begin
         r = a + b;
         s = $signed({a[63], a}) + $signed({b[63], b});
         of = (s != $signed({r[63], r}));
      end
      zf = (r == 64'd0);
      sf = r[63];
      lt = mcc[1] ^ mcc[0];
      case (f.ifun)
         4'h0: e.cnd = 1'b1;
         4'h1: e.cnd = lt | mcc[2];
         4'h2: e.cnd = lt;
         4'h3: e.cnd = mcc[2];
         4'h4: e.cnd = ~mcc[2];
         4'h5: e.cnd = ~lt;
         4'h6: e.cnd = ~lt & ~mcc[2];
         default: e.cnd = 1'b0;
      endcase
      e.due = cyc + 1;
      e.icode = f.icode; e.ifun = f.ifun; e.srca = f.srca; e.srcb = f.srcb;
      e.dstm = f.dstm; e.vala = f.vala; e.vale = r; e.cc = mcc;
      e.dste = (f.icode == IcCmovq && !e.cnd) ? RNone : f.dste;
      sb_q.push_back(e);
      if (!rst && f.icode == IcOpq && !(Guard && (em || ew))) mcc = {zf, sf, of};
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            chk("missed_slot", 64'(cyc), 64'(e.due));
         end
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("E_icode", 64'(ex_if.E_icode_o), 64'(e.icode));
            chk("E_ifun", 64'(ex_if.E_ifun_o), 64'(e.ifun));
            chk("E_srcA", 64'(ex_if.E_srcA_o), 64'(e.srca));
            chk("E_srcB", 64'(ex_if.E_srcB_o), 64'(e.srcb));
            chk("E_dstM", 64'(ex_if.E_dstM_o), 64'(e.dstm));
            chk("E_valA", ex_if.E_valA_o, e.vala);
            chk("e_valE", ex_if.e_valE_o, e.vale);
            chk("e_dstE", 64'(ex_if.e_dstE_o), 64'(e.dste));
            chk("e_Cnd", 64'(ex_if.e_Cnd_o), 64'(e.cnd));
            chk("cc", 64'(ex_if.cc_o), 64'(e.cc));
         end
      end
   end

   function automatic logic [63:0] rval();
      logic [63:0] pool [6];
      pool[0] = 64'h0; pool[1] = 64'h1; pool[2] = 64'h8000_0000_0000_0000;
      pool[3] = 64'h7FFF_FFFF_FFFF_FFFF; pool[4] = 64'hFFFF_FFFF_FFFF_FFFF; pool[5] = 64'h5;
      if ($urandom_range(0, 9) < 4) return pool[$urandom_range(0, 5)];
      return {$urandom(), $urandom()};
   endfunction

   initial begin : stim
      logic [3:0] icodes [16];
      logic [3:0] dsts [4];
      ins_t nop;
      ins_t ri;
      icodes = '{IcHalt, IcNop, IcCmovq, IcIrmovq, IcRmmovq, IcMrmovq, IcOpq, IcOpq,
                 IcOpq, IcJxx, IcCall, IcRet, IcPushq, IcPopq, IcCmovq, 4'hE};
      dsts = '{RRsp, RNone, 4'h2, 4'h7};
      nop = mk(IcNop, 4'h0, 64'h0, 64'h0, 64'h0, RNone);
      ex_if.E_bubble_i = 1'b0; ex_if.m_exc_i = 1'b0; ex_if.W_exc_i = 1'b0;
      ex_if.d_icode_i = IcNop; ex_if.d_ifun_i = 4'h0; ex_if.d_valC_i = '0;
      ex_if.d_valA_i = '0; ex_if.d_valB_i = '0; ex_if.d_dstE_i = RNone;
      ex_if.d_dstM_i = RNone; ex_if.d_srcA_i = RNone; ex_if.d_srcB_i = RNone;

      issue(mk(IcOpq, 4'h0, 64'h0, 64'h3, 64'h4, 4'h2), 1'b0, 1'b0, 1'b0, 1'b1);
      issue(mk(IcOpq, 4'h0, 64'h0, 64'h3, 64'h4, 4'h2), 1'b0, 1'b0, 1'b0, 1'b1);
      // Sub overflow, then xor to zero feeding two cmovs.
      issue(mk(IcOpq, 4'h1, 64'h0, 64'h1, 64'h8000_0000_0000_0000, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcOpq, 4'h3, 64'h0, 64'h5, 64'h5, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcCmovq, 4'h3, 64'h0, 64'h9, 64'h0, 4'h2), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcCmovq, 4'h4, 64'h0, 64'h9, 64'h0, 4'h2), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcPushq, 4'h0, 64'h0, 64'h0, 64'h100, RRsp), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcPopq, 4'h0, 64'h0, 64'h0, 64'h100, RRsp), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcOpq, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h1), 1'b1, 1'b0, 1'b0, 1'b0);
      issue(nop, 1'b0, 1'b0, 1'b0, 1'b0);
      // Clear ZF, then an OPQ with zero result under a memory-stage exception.
      issue(mk(IcOpq, 4'h0, 64'h0, 64'h1, 64'h1, 4'h1), 1'b0, 1'b0, 1'b0, 1'b0);
      issue(mk(IcOpq, 4'h3, 64'h0, 64'h7, 64'h7, 4'h1), 1'b0, 1'b1, 1'b0, 1'b0);
      issue(mk(IcCmovq, 4'h3, 64'h0, 64'h2, 64'h0, 4'h6), 1'b0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         ri = mk(icodes[$urandom_range(0, 15)], 4'($urandom_range(0, 15)), rval(), rval(),
                 rval(), dsts[$urandom_range(0, 3)]);
         if ($urandom_range(0, 3) != 0) ri.ifun = 4'($urandom_range(0, 7));
         ri.dstm = dsts[$urandom_range(0, 3)];
         ri.srca = 4'($urandom_range(0, 15));
         ri.srcb = 4'($urandom_range(0, 15));
         issue(ri, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 6) == 0), ($urandom_range(0, 49) == 0));
      end

      issue(nop, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(nop, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6 && sb_q.size() > 0; k++) @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
